pkt_proc_fifo_fsm: RTL and testbench
====================================

Name: pkt_proc_fifo_fsm

Overview:
- Packet-oriented FIFO with internal single-clock memory and a write-side packet FSM.
- Accepts packets of 32-bit words framed by in_sop/in_eop, each with a declared length.
- Drops packets that do not fit or are malformed; replays stored packets on dequeue with out_sop/out_eop.
- Reports level, full/empty, almost-full/empty, overflow, underflow and drop status; sits between an ingress packet source and an egress consumer.

Parameters:
- DATA_W, 32, payload word width.
- DEPTH, 16384, memory depth in words (power of 2). Each entry stores the word plus sop/eop flags.
- LVL_W, 15, width of the level counter (log2(DEPTH)+1).

Ports:
- pck_proc_int_mem_fsm_clk  in  1  single clock; all logic on posedge.
- pck_proc_int_mem_fsm_rstn  in  1  asynchronous active-low reset.
- pck_proc_int_mem_fsm_sw_rstn  in  1  synchronous active-low soft reset; same effect as rstn.
- empty_de_assert  in  1  1 = cut-through, 0 = store-and-forward.
- enq_req  in  1  write word valid.
- in_sop  in  1  first word of packet.
- wr_data_i  in  32  write data.
- in_eop  in  1  last word of packet.
- pck_len_valid  in  1  pck_len_i valid; sampled with in_sop.
- pck_len_i  in  12  packet length in words.
- deq_req  in  1  read request.
- out_sop  out  1  word on rd_data_o is first of packet.
- rd_data_o  out  32  read data.
- out_eop  out  1  word on rd_data_o is last of packet.
- pck_proc_full  out  1  level == DEPTH.
- pck_proc_empty  out  1  nothing readable.
- pck_proc_almost_full_value  in  5  almost-full margin.
- pck_proc_almost_empty_value  in  5  almost-empty threshold.
- pck_proc_almost_full  out  1  level >= DEPTH - almost_full_value.
- pck_proc_almost_empty  out  1  level <= almost_empty_value.
- pck_proc_overflow  out  1  one-cycle pulse.
- pck_proc_underflow  out  1  one-cycle pulse.
- packet_drop  out  1  one-cycle pulse.
- pck_proc_wr_lvl  out  15  words currently stored.

Behaviour:
- Reset (rstn low, async; or sw_rstn low at a clock edge):
  - Pointers, level and FSM go to IDLE.
  - All outputs 0, except pck_proc_empty = 1 and pck_proc_almost_empty = 1.
  - Memory contents are not cleared.
- All outputs are registered. Status flags are computed from the updated level, so they change in the same cycle as pck_proc_wr_lvl.
- Write FSM states: IDLE, WRITE, DROP.
- IDLE:
  - enq_req & in_sop accepts the packet if pck_len_valid = 1, pck_len_i != 0 and pck_len_i <= DEPTH - level. The FSM then records the start pointer, writes the word and goes to WRITE.
  - If that first word also has in_eop and len = 1, the packet commits and the FSM stays in IDLE.
  - Any other case pulses packet_drop and goes to DROP; if in_eop is set the same cycle, it stays in IDLE instead.
  - enq_req without in_sop is ignored.
- WRITE:
  - Each enq_req writes one word and increments the word count.
  - On in_eop with count == len, the packet commits and the FSM returns to IDLE.
  - On in_eop with count != len, count exceeding len, or in_sop arriving, the FSM pulses packet_drop and rolls the write pointer and level back to the packet start (never behind the read pointer).
  - After rollback it goes to IDLE on eop, otherwise to DROP.
- DROP: discard words until enq_req & in_eop, then go to IDLE.
- Overflow: enq_req while pck_proc_full pulses pck_proc_overflow; the word is discarded and the packet is dropped.
- Read availability:
  - Store-and-forward: only committed words are readable.
  - Cut-through: any written word is readable.
- pck_proc_empty = no readable word.
- deq_req with a readable word: rd_data_o, out_sop and out_eop update on the next clock edge (1-cycle latency), the read pointer advances and level decrements. Outputs hold their value otherwise.
- deq_req while empty pulses pck_proc_underflow; no pointer change.
- Simultaneous read and write leaves level unchanged.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then one 4-word packet (len = 4, data 1..4), then 4 deq_req -> wr_lvl reaches 4 then returns to 0. rd_data_o = 1,2,3,4 one cycle after each deq_req; out_sop on word 1, out_eop on word 4; empty = 1 at end.
- Store-and-forward: write 3 of 5 words -> empty stays 1. Cut-through with the same stimulus -> empty = 0 one cycle after the first write.
- Packet with len = 3 but eop on word 2 -> packet_drop pulses once and wr_lvl returns to 0. A following valid packet reads back intact.
- Fill to DEPTH, then enq_req -> full = 1, overflow pulses 1 cycle. deq_req on an empty FIFO -> underflow pulses 1 cycle.
- almost_full_value = 4 -> almost_full rises at wr_lvl = 16380. almost_empty_value = 2 -> almost_empty = 1 while wr_lvl <= 2.
- sw_rstn low for 1 cycle mid-packet -> wr_lvl = 0 and empty = 1 next cycle. rstn low asynchronously mid-read -> outputs cleared immediately.

Source files
------------

// File: rtl/pkt_proc_fifo_fsm.sv
// Packet FIFO: single-clock word memory with a write-side packet FSM that
// admits, commits or drops framed packets, and a 1-cycle-latency read port.
// Ports:
//   pck_proc_int_mem_fsm_clk / _rstn / _sw_rstn : clock, async and soft reset
//   empty_de_assert                             : 1 cut-through, 0 store-and-forward
//   enq_req, in_sop, in_eop, wr_data_i          : ingress word stream
//   pck_len_valid, pck_len_i                    : declared length, sampled with in_sop
//   deq_req -> rd_data_o, out_sop, out_eop      : egress word stream
//   pck_proc_* status, packet_drop, pck_proc_wr_lvl : level and event flags
module pkt_proc_fifo_fsm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned LVL_W  = 15
) (
  input  logic              pck_proc_int_mem_fsm_clk,
  input  logic              pck_proc_int_mem_fsm_rstn,
  input  logic              pck_proc_int_mem_fsm_sw_rstn,
  input  logic              empty_de_assert,
  input  logic              enq_req,
  input  logic              in_sop,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              in_eop,
  input  logic              pck_len_valid,
  input  logic [11:0]       pck_len_i,
  input  logic              deq_req,
  output logic              out_sop,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              out_eop,
  output logic              pck_proc_full,
  output logic              pck_proc_empty,
  input  logic [4:0]        pck_proc_almost_full_value,
  input  logic [4:0]        pck_proc_almost_empty_value,
  output logic              pck_proc_almost_full,
  output logic              pck_proc_almost_empty,
  output logic              pck_proc_overflow,
  output logic              pck_proc_underflow,
  output logic              packet_drop,
  output logic [LVL_W-1:0]  pck_proc_wr_lvl
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LEN_W = 12;
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_e;

  // Pointers carry one extra wrap bit so that full and empty are distinct.
  state_e             state_q, state_n;
  logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [LVL_W-1:0]   commit_ptr_q, commit_ptr_n, start_ptr_q, start_ptr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [LEN_W-1:0]   len_q, len_n;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   rd_ent, wr_ent;
  logic               wr_en, rd_en, rollback, commit;

  logic [LVL_W-1:0]   lvl_cur, cmt_cur, avail_cur, lvl_n, cmt_n, avail_n;
  logic [LVL_W-1:0]   rd_ahead, pkt_span;

  logic               out_sop_n, out_eop_n, full_n, empty_n, afull_n, aempty_n;
  logic               ovf_n, udf_n, drop_n;
  logic [DATA_W-1:0]  rd_data_n;

  assign rd_ent = mem[rd_ptr_q[AW-1:0]];

  // Next-state, pointer and flag computation; soft reset overrides everything.
  always_comb begin
    state_n     = state_q;
    start_ptr_n = start_ptr_q;
    cnt_n       = cnt_q;
    len_n       = len_q;
    wr_en       = 1'b0;
    wr_ent      = {1'b0, in_eop, wr_data_i};
    rollback    = 1'b0;
    commit      = 1'b0;
    drop_n      = 1'b0;
    ovf_n       = enq_req & pck_proc_full;

    lvl_cur = wr_ptr_q - rd_ptr_q;
    cmt_cur = commit_ptr_q - rd_ptr_q;
    // Reader may run ahead of the commit point in cut-through; treat as nothing readable.
    if (empty_de_assert)        avail_cur = lvl_cur;
    else if (cmt_cur > lvl_cur) avail_cur = '0;
    else                        avail_cur = cmt_cur;

    rd_en    = deq_req & (avail_cur != '0);
    udf_n    = deq_req & (avail_cur == '0);
    rd_ptr_n = rd_ptr_q + LVL_W'(rd_en);

    unique case (state_q)
      ST_IDLE: begin
        if (enq_req && in_sop) begin
          if (pck_len_valid && (pck_len_i != '0) &&
              (LVL_W'(pck_len_i) <= LVL_W'(DEPTH) - lvl_cur) &&
              (!in_eop || pck_len_i == LEN_W'(1))) begin
            wr_en       = 1'b1;
            wr_ent      = {1'b1, in_eop, wr_data_i};
            start_ptr_n = wr_ptr_q;
            cnt_n       = CNT_W'(1);
            len_n       = pck_len_i;
            if (in_eop) commit  = 1'b1;
            else        state_n = ST_WRITE;
          end else begin
            drop_n  = 1'b1;
            state_n = in_eop ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_WRITE: begin
        if (enq_req) begin
          if (pck_proc_full || in_sop || cnt_q >= CNT_W'(len_q)) begin
            drop_n   = 1'b1;
            rollback = 1'b1;
            state_n  = in_eop ? ST_IDLE : ST_DROP;
          end else if (in_eop && (cnt_q + CNT_W'(1) != CNT_W'(len_q))) begin
            drop_n   = 1'b1;
            rollback = 1'b1;
            state_n  = ST_IDLE;
          end else begin
            wr_en = 1'b1;
            cnt_n = cnt_q + CNT_W'(1);
            if (in_eop) begin
              commit  = 1'b1;
              state_n = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (enq_req && in_eop) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Rollback to packet start, but never behind words the reader already took.
    rd_ahead = rd_ptr_n - start_ptr_q;
    pkt_span = wr_ptr_q - start_ptr_q;
    if (rollback)
      wr_ptr_n = (rd_ahead <= pkt_span) ? rd_ptr_n : start_ptr_q;
    else
      wr_ptr_n = wr_ptr_q + LVL_W'(wr_en);
    commit_ptr_n = commit ? wr_ptr_n : commit_ptr_q;

    lvl_n = wr_ptr_n - rd_ptr_n;
    cmt_n = commit_ptr_n - rd_ptr_n;
    if (empty_de_assert)    avail_n = lvl_n;
    else if (cmt_n > lvl_n) avail_n = '0;
    else                    avail_n = cmt_n;

    full_n    = (lvl_n == LVL_W'(DEPTH));
    empty_n   = (avail_n == '0);
    afull_n   = (lvl_n >= LVL_W'(DEPTH) - LVL_W'(pck_proc_almost_full_value));
    aempty_n  = (lvl_n <= LVL_W'(pck_proc_almost_empty_value));
    rd_data_n = rd_en ? rd_ent[DATA_W-1:0] : rd_data_o;
    out_sop_n = rd_en ? rd_ent[DATA_W+1]   : out_sop;
    out_eop_n = rd_en ? rd_ent[DATA_W]     : out_eop;

    if (!pck_proc_int_mem_fsm_sw_rstn) begin
      state_n      = ST_IDLE;
      wr_en        = 1'b0;
      wr_ptr_n     = '0;
      rd_ptr_n     = '0;
      commit_ptr_n = '0;
      start_ptr_n  = '0;
      cnt_n        = '0;
      len_n        = '0;
      lvl_n        = '0;
      full_n       = 1'b0;
      empty_n      = 1'b1;
      afull_n      = 1'b0;
      aempty_n     = 1'b1;
      ovf_n        = 1'b0;
      udf_n        = 1'b0;
      drop_n       = 1'b0;
      rd_data_n    = '0;
      out_sop_n    = 1'b0;
      out_eop_n    = 1'b0;
    end
  end

  // State, pointers and all registered outputs.
  always_ff @(posedge pck_proc_int_mem_fsm_clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) begin
      state_q               <= ST_IDLE;
      wr_ptr_q              <= '0;
      rd_ptr_q              <= '0;
      commit_ptr_q          <= '0;
      start_ptr_q           <= '0;
      cnt_q                 <= '0;
      len_q                 <= '0;
      pck_proc_wr_lvl       <= '0;
      pck_proc_full         <= 1'b0;
      pck_proc_empty        <= 1'b1;
      pck_proc_almost_full  <= 1'b0;
      pck_proc_almost_empty <= 1'b1;
      pck_proc_overflow     <= 1'b0;
      pck_proc_underflow    <= 1'b0;
      packet_drop           <= 1'b0;
      rd_data_o             <= '0;
      out_sop               <= 1'b0;
      out_eop               <= 1'b0;
    end else begin
      state_q               <= state_n;
      wr_ptr_q              <= wr_ptr_n;
      rd_ptr_q              <= rd_ptr_n;
      commit_ptr_q          <= commit_ptr_n;
      start_ptr_q           <= start_ptr_n;
      cnt_q                 <= cnt_n;
      len_q                 <= len_n;
      pck_proc_wr_lvl       <= lvl_n;
      pck_proc_full         <= full_n;
      pck_proc_empty        <= empty_n;
      pck_proc_almost_full  <= afull_n;
      pck_proc_almost_empty <= aempty_n;
      pck_proc_overflow     <= ovf_n;
      pck_proc_underflow    <= udf_n;
      packet_drop           <= drop_n;
      rd_data_o             <= rd_data_n;
      out_sop               <= out_sop_n;
      out_eop               <= out_eop_n;
    end
  end

  // Packet memory; contents survive reset.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_ent;
  end

endmodule

// File: tb/tb_pkt_proc_fifo_fsm.sv
// Directed bench for pkt_proc_fifo_fsm: framing, cut-through vs
// store-and-forward, drop/rollback, full/overflow, underflow, thresholds, resets.
module tb_pkt_proc_fifo_fsm;

  logic        clk = 1'b0;
  logic        rstn, sw_rstn, ct_mode;
  logic        enq_req, in_sop, in_eop, len_valid, deq_req;
  logic [31:0] wr_data;
  logic [11:0] len;
  logic [4:0]  af_val, ae_val;
  logic        out_sop, out_eop, full, empty, afull, aempty, ovf, udf, drop;
  logic [31:0] rd_data;
  logic [14:0] lvl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pkt_proc_fifo_fsm dut (
    .pck_proc_int_mem_fsm_clk    (clk),
    .pck_proc_int_mem_fsm_rstn   (rstn),
    .pck_proc_int_mem_fsm_sw_rstn(sw_rstn),
    .empty_de_assert             (ct_mode),
    .enq_req                     (enq_req),
    .in_sop                      (in_sop),
    .wr_data_i                   (wr_data),
    .in_eop                      (in_eop),
    .pck_len_valid               (len_valid),
    .pck_len_i                   (len),
    .deq_req                     (deq_req),
    .out_sop                     (out_sop),
    .rd_data_o                   (rd_data),
    .out_eop                     (out_eop),
    .pck_proc_full               (full),
    .pck_proc_empty              (empty),
    .pck_proc_almost_full_value  (af_val),
    .pck_proc_almost_empty_value (ae_val),
    .pck_proc_almost_full        (afull),
    .pck_proc_almost_empty       (aempty),
    .pck_proc_overflow           (ovf),
    .pck_proc_underflow          (udf),
    .packet_drop                 (drop),
    .pck_proc_wr_lvl             (lvl)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write cycle; inputs return to idle afterwards.
  task automatic push(input logic [31:0] d, input logic s, input logic e, input logic [11:0] l);
    enq_req = 1'b1; in_sop = s; in_eop = e; wr_data = d; len = l; len_valid = s;
    tick();
    enq_req = 1'b0; in_sop = 1'b0; in_eop = 1'b0; len_valid = 1'b0;
  endtask

  task automatic pop(input logic [31:0] d, input logic s, input logic e, input logic [14:0] l);
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    chk("pop_data", rd_data, d);
    chk("pop_sop", 32'(out_sop), 32'(s));
    chk("pop_eop", 32'(out_eop), 32'(e));
    chk("pop_lvl", 32'(lvl), 32'(l));
  endtask

  initial begin
    rstn = 1'b0; sw_rstn = 1'b1; ct_mode = 1'b0;
    enq_req = 1'b0; in_sop = 1'b0; in_eop = 1'b0; len_valid = 1'b0; deq_req = 1'b0;
    wr_data = '0; len = '0; af_val = 5'd4; ae_val = 5'd2;
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_lvl", 32'(lvl), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    rstn = 1'b1;
    tick();

    // Basic 4-word packet, store-and-forward.
    for (int k = 1; k <= 4; k++) begin
      push(32'(k), k == 1, k == 4, 12'd4);
      chk("p1_lvl", 32'(lvl), 32'(k));
      if (k == 2) chk("p1_aempty_at2", 32'(aempty), 32'd1);
      if (k == 3) chk("p1_aempty_at3", 32'(aempty), 32'd0);
      chk("p1_empty", 32'(empty), (k == 4) ? 32'd0 : 32'd1);
    end
    for (int k = 1; k <= 4; k++) pop(32'(k), k == 1, k == 4, 15'(4 - k));
    chk("p1_empty_end", 32'(empty), 32'd1);

    // Store-and-forward partial packet stays invisible; soft reset mid-packet.
    for (int k = 1; k <= 3; k++) push(32'h20 + 32'(k), k == 1, 1'b0, 12'd5);
    chk("saf_empty", 32'(empty), 32'd1);
    chk("saf_lvl", 32'(lvl), 32'd3);
    sw_rstn = 1'b0;
    tick();
    sw_rstn = 1'b1;
    chk("swrst_lvl", 32'(lvl), 32'd0);
    chk("swrst_empty", 32'(empty), 32'd1);

    // Cut-through: first word readable right away; read overlaps write.
    ct_mode = 1'b1;
    push(32'h11, 1'b1, 1'b0, 12'd5);
    chk("ct_empty", 32'(empty), 32'd0);
    push(32'h12, 1'b0, 1'b0, 12'd5);
    push(32'h13, 1'b0, 1'b0, 12'd5);
    deq_req = 1'b1;
    push(32'h14, 1'b0, 1'b0, 12'd5);
    deq_req = 1'b0;
    chk("ct_rw_data", rd_data, 32'h11);
    chk("ct_rw_lvl", 32'(lvl), 32'd3);
    push(32'h15, 1'b0, 1'b1, 12'd5);
    chk("ct_lvl", 32'(lvl), 32'd4);
    for (int k = 2; k <= 5; k++) pop(32'h10 + 32'(k), 1'b0, k == 5, 15'(5 - k));
    ct_mode = 1'b0;

    // Short packet (eop on word 2 of 3) is dropped and rolled back.
    push(32'h31, 1'b1, 1'b0, 12'd3);
    push(32'h32, 1'b0, 1'b1, 12'd3);
    chk("short_drop", 32'(drop), 32'd1);
    chk("short_lvl", 32'(lvl), 32'd0);
    tick();
    chk("short_drop_clr", 32'(drop), 32'd0);
    push(32'hA1, 1'b1, 1'b0, 12'd2);
    push(32'hA2, 1'b0, 1'b1, 12'd2);
    pop(32'hA1, 1'b1, 1'b0, 15'd1);
    pop(32'hA2, 1'b0, 1'b1, 15'd0);

    // Underflow on empty; data holds.
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    chk("udf_pulse", 32'(udf), 32'd1);
    chk("udf_hold", rd_data, 32'hA2);
    tick();
    chk("udf_clr", 32'(udf), 32'd0);

    // Fill: four 4095-word packets (16380 words) then one 4-word packet.
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 4095; w++) begin
        push(32'h1000_0000 + 32'(p * 65536 + w), w == 0, w == 4094, 12'd4095);
        if (p == 3 && w == 4093) chk("af_at16379", 32'(afull), 32'd0);
        if (p == 3 && w == 4094) begin
          chk("af_at16380", 32'(afull), 32'd1);
          chk("lvl_16380", 32'(lvl), 32'd16380);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      push(32'h50 + 32'(k), k == 0, k == 3, 12'd4);
      if (k == 2) chk("full_at16383", 32'(full), 32'd0);
    end
    chk("full_set", 32'(full), 32'd1);
    chk("full_lvl", 32'(lvl), 32'd16384);
    push(32'hEE, 1'b1, 1'b1, 12'd1);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("ovf_drop", 32'(drop), 32'd1);
    chk("ovf_lvl", 32'(lvl), 32'd16384);
    tick();
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Read first stored word, then async reset mid-read.
    pop(32'h1000_0000, 1'b1, 1'b0, 15'd16383);
    deq_req = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("arst_data", rd_data, 32'd0);
    chk("arst_sop", 32'(out_sop), 32'd0);
    chk("arst_lvl", 32'(lvl), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    deq_req = 1'b0;
    #3 rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
